// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: a DEPTH-stage elastic register chain, WIDTH bits per stage,
// with a valid/ready handshake at both ends and an occupancy count.
// Empty stages (bubbles) collapse, so the chain stalls only when it is full
// and the consumer is backpressuring. out_data comes straight from the last
// register, so there is no combinational path from in_data to out_data.
// The only combinational path from the consumer to the producer is the ready chain.
// Optional feature: define PIPE_FLUSH_EN to add a synchronous flush input.
// A flush drops every held word and blocks input for that cycle.
module pipe_reg_chain #(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef PIPE_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  // Stage 0 is the input side; stage DEPTH-1 drives the output port.
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];

  // A stage may load a new word when its content leaves this cycle.
  logic [DEPTH-1:0] adv;

  // Word offered to each stage by the stage that feeds it.
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] up_data [DEPTH];

  logic flush_now;
  logic in_xfer;
  logic out_xfer;

`ifdef PIPE_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  // The recursive advance term !vld[i+1] | adv[i+1] unrolls to "consumer is ready,
  // or some stage downstream of i is empty". That form avoids a combinational loop
  // through the adv vector itself.
  always_comb begin
    adv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic hole;
      hole = 1'b0;
      for (int j = i + 1; j < DEPTH; j++) begin
        if (!vld[j]) begin
          hole = 1'b1;
        end
      end
      adv[i] = out_ready | hole;
    end
  end

  // Connect each stage to its upstream neighbour; stage 0 is fed by the input port.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0) begin
        up_valid[i] = in_valid;
        up_data[i]  = in_data;
      end else begin
        up_valid[i] = vld[i-1];
        up_data[i]  = dat[i-1];
      end
    end
  end

  assign in_ready  = !flush_now && (!vld[0] || adv[0]);
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Stage registers: load from upstream when empty or draining, otherwise hold.
  // Data is only captured alongside a valid word, so bubbles never overwrite data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat[i] <= RESET_DATA;
      end
    end else if (flush_now) begin
      vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!vld[i] || adv[i]) begin
          vld[i] <= up_valid[i];
          if (up_valid[i]) begin
            dat[i] <= up_data[i];
          end
        end
      end
    end
  end

  // Occupancy: +1 per accept, -1 per delivery.
  // The count cannot leave 0..DEPTH because the handshake blocks overflow and underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush_now) begin
      count <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
